rst_sequencer: RTL and testbench

Staged reset release controller that consumes the asynchronous active-high system reset and distributes three ordered reset domains (I/O, core, peripherals) to the PicoBlaze emulation platform. Every output asserts immediately on `reset`. On release, outputs deassert in sequence, I/O first, then core, then peripherals, with programmable hold and gap counts. It also accepts a single-cycle software reset request from the core and replays the same sequence.

---
 rtl/rst_sequencer.sv | 153 +++++++++++++++
 tb/tb_rst_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// ----------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset release controller. The asynchronous system reset forces
// all three domain resets high at once. After reset is released, the
// domains come out of reset in order: I/O first, then core, then
// peripherals. HOLD_CYCLES sets the hold time before the I/O release, and
// STAGE_GAP sets the spacing between later releases. A one-cycle software
// request from the core restarts the same sequence.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   sw_rst_req  in   software reset request, one-cycle pulse, synchronous
//   rst_io      out  I/O domain reset, released first
//   rst_core    out  core domain reset, released second
//   rst_periph  out  peripheral domain reset, released last
//   ready       out  high only while every domain is out of reset
//   rst_cause   out  cause of the last sequence: 01 = hardware, 10 = software
//
// State table
//   state      | meaning
//   S_HOLD     | all domains in reset, counting HOLD_CYCLES
//   S_REL_IO   | I/O released, counting STAGE_GAP before the core release
//   S_REL_CORE | core released, counting STAGE_GAP before the peripheral release
//   S_RUN      | all domains released, counter idle
// ----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_rst_req,
    output logic       rst_io,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [1:0] rst_cause
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    localparam logic [1:0] CAUSE_HW = 2'b01;
    localparam logic [1:0] CAUSE_SW = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_REL_IO   = 2'd1,
        S_REL_CORE = 2'd2,
        S_RUN      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_io_q, rst_io_d;
    logic          rst_core_q, rst_core_d;
    logic          rst_periph_q, rst_periph_d;
    logic          ready_q, ready_d;
    logic [1:0]    cause_q, cause_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            rst_io_q     <= 1'b1;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            ready_q      <= 1'b0;
            cause_q      <= CAUSE_HW;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_io_q     <= rst_io_d;
            rst_core_q   <= rst_core_d;
            rst_periph_q <= rst_periph_d;
            ready_q      <= ready_d;
            cause_q      <= cause_d;
        end
    end

    // Each output is computed one cycle early, so every output comes
    // directly from a flop and releases on the edge that changes state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_io_d     = rst_io_q;
        rst_core_d   = rst_core_q;
        rst_periph_d = rst_periph_q;
        ready_d      = ready_q;
        cause_d      = cause_q;

        if (sw_rst_req) begin
            // A request in any state, including HOLD, restarts the sequence.
            state_d      = S_HOLD;
            cnt_d        = '0;
            rst_io_d     = 1'b1;
            rst_core_d   = 1'b1;
            rst_periph_d = 1'b1;
            ready_d      = 1'b0;
            cause_d      = CAUSE_SW;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = S_REL_IO;
                        cnt_d    = '0;
                        rst_io_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REL_IO: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d    = S_REL_CORE;
                        cnt_d      = '0;
                        rst_core_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REL_CORE: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d      = S_RUN;
                        cnt_d        = '0;
                        rst_periph_d = 1'b0;
                        ready_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rst_io     = rst_io_q;
    assign rst_core   = rst_core_q;
    assign rst_periph = rst_periph_q;
    assign ready      = ready_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

    localparam int H = 16;
    localparam int G = 4;

    logic       clk;
    logic       reset, sw_rst_req;
    logic       rst_io, rst_core, rst_periph, ready;
    logic [1:0] rst_cause;

    logic       reset2, sw2;
    logic       io2, core2, per2, rdy2;
    logic [1:0] cause2;

    rst_sequencer #(.HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
        .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
        .rst_io(rst_io), .rst_core(rst_core), .rst_periph(rst_periph),
        .ready(ready), .rst_cause(rst_cause)
    );

    rst_sequencer #(.HOLD_CYCLES(1), .STAGE_GAP(1)) dut_min (
        .clk(clk), .reset(reset2), .sw_rst_req(sw2),
        .rst_io(io2), .rst_core(core2), .rst_periph(per2),
        .ready(rdy2), .rst_cause(cause2)
    );

    // Packed as {rst_io, rst_core, rst_periph, ready, rst_cause}.
    logic [5:0] outs, outs2;
    assign outs  = {rst_io, rst_core, rst_periph, ready, rst_cause};
    assign outs2 = {io2, core2, per2, rdy2, cause2};

    int vectors = 0;
    int errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (io,core,periph,ready,cause)", name, got, exp);
        end
    endtask

    // Timing model: k counts edges since the sequence start. Hardware reset
    // and software request both set k to 0. Each release happens when k
    // reaches its release edge number.
    int         k      = 0;
    logic [1:0] mcause = 2'b01;
    logic [5:0] exp_q[$];

    task automatic model_push(input logic r, input logic s);
        logic io_e, core_e, per_e;
        if (r) begin
            k = 0; mcause = 2'b01;
        end else if (s) begin
            k = 0; mcause = 2'b10;
        end else if (k < 1000) begin
            k++;
        end
        io_e   = (k < H);
        core_e = (k < H + G);
        per_e  = (k < H + 2 * G);
        exp_q.push_back({io_e, core_e, per_e, ~per_e, mcause});
    endtask

    task automatic pop_check(input string name);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL %s: got empty scoreboard required entry", name);
        end else begin
            e = exp_q.pop_front();
            check(name, outs, e);
        end
    endtask

    task automatic cycle(input logic r, input logic s);
        @(negedge clk);
        reset = r; sw_rst_req = s;
        model_push(r, s);
        @(posedge clk);
        #1;
        pop_check("scoreboard");
    endtask

    task automatic cycle2(input logic r, input logic s, input logic [5:0] exp, input string name);
        @(negedge clk);
        reset2 = r; sw2 = s;
        @(posedge clk);
        #1;
        check(name, outs2, exp);
    endtask

    // Ordering invariant and output consistency on both instances.
    logic started = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if ((rst_core < rst_io) || (rst_periph < rst_core) || (ready !== ~rst_periph)
                || (rst_cause == 2'b00) || (rst_cause == 2'b11)) begin
                errors++;
                $display("FAIL invariant: got %b required ordered outputs", outs);
            end
            vectors++;
            if ((core2 < io2) || (per2 < core2) || (rdy2 !== ~per2)
                || (cause2 == 2'b00) || (cause2 == 2'b11)) begin
                errors++;
                $display("FAIL invariant_min: got %b required ordered outputs", outs2);
            end
        end
    end

    typedef struct {
        logic       r;
        logic       s;
        int         n;
        logic [5:0] exp;
        string      name;
    } row_t;

    row_t rows[$];

    initial begin
        // Power-on: edges 16/20/24 release. Software reset at 40 gives 56/60/64.
        rows.push_back('{1'b1, 1'b0,  3, 6'b111001, "poweron_reset"});
        rows.push_back('{1'b0, 1'b0, 15, 6'b111001, "edge15_hold"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b011001, "edge16_io"});
        rows.push_back('{1'b0, 1'b0,  3, 6'b011001, "edge19"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b001001, "edge20_core"});
        rows.push_back('{1'b0, 1'b0,  3, 6'b001001, "edge23"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b000101, "edge24_run"});
        rows.push_back('{1'b0, 1'b0, 15, 6'b000101, "edge39_run"});
        rows.push_back('{1'b0, 1'b1,  1, 6'b111010, "edge40_swreq"});
        rows.push_back('{1'b0, 1'b0, 15, 6'b111010, "edge55_hold"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b011010, "edge56_io"});
        rows.push_back('{1'b0, 1'b0,  4, 6'b001010, "edge60_core"});
        rows.push_back('{1'b0, 1'b0,  4, 6'b000110, "edge64_run"});
        // Mid-sequence request at edge 18 gives releases at 34/38/42.
        rows.push_back('{1'b1, 1'b0,  2, 6'b111001, "mid_reset"});
        rows.push_back('{1'b0, 1'b0, 17, 6'b011001, "mid_edge17"});
        rows.push_back('{1'b0, 1'b1,  1, 6'b111010, "mid_edge18_req"});
        rows.push_back('{1'b0, 1'b0, 15, 6'b111010, "mid_edge33"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b011010, "mid_edge34_io"});
        rows.push_back('{1'b0, 1'b0,  4, 6'b001010, "mid_edge38_core"});
        rows.push_back('{1'b0, 1'b0,  4, 6'b000110, "mid_edge42_run"});
        // A second request during HOLD restarts the hold count.
        rows.push_back('{1'b0, 1'b1,  1, 6'b111010, "ext_req1"});
        rows.push_back('{1'b0, 1'b0,  5, 6'b111010, "ext_gap"});
        rows.push_back('{1'b0, 1'b1,  1, 6'b111010, "ext_req2"});
        rows.push_back('{1'b0, 1'b0, 15, 6'b111010, "ext_hold15"});
        rows.push_back('{1'b0, 1'b0,  1, 6'b011010, "ext_io"});
        rows.push_back('{1'b0, 1'b0,  8, 6'b000110, "ext_run"});

        reset = 1'b1; sw_rst_req = 1'b0;
        reset2 = 1'b1; sw2 = 1'b0;
        #1;
        check("reset_state", outs, 6'b111001);
        check("reset_state_min", outs2, 6'b111001);
        started = 1'b1;

        foreach (rows[i]) begin
            for (int c = 0; c < rows[i].n; c++) cycle(rows[i].r, rows[i].s);
            check(rows[i].name, outs, rows[i].exp);
        end

        // Asynchronous reset between edges while in RUN with cause 10.
        @(negedge clk);
        sw_rst_req = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset", outs, 6'b111001);
        model_push(1'b1, 1'b0);
        @(posedge clk);
        #1;
        pop_check("async_edge");
        cycle(1'b1, 1'b0);
        for (int c = 0; c < 24; c++) cycle(1'b0, 1'b0);
        check("async_repeat_run", outs, 6'b000101);

        // Minimum parameters, including reset and sw_rst_req both high.
        cycle2(1'b1, 1'b1, 6'b111001, "min_reset_and_req");
        cycle2(1'b0, 1'b0, 6'b011001, "min_edge1");
        cycle2(1'b0, 1'b0, 6'b001001, "min_edge2");
        cycle2(1'b0, 1'b0, 6'b000101, "min_edge3");
        cycle2(1'b0, 1'b1, 6'b111010, "min_swreq");
        cycle2(1'b0, 1'b0, 6'b011010, "min_sw_edge1");
        cycle2(1'b0, 1'b0, 6'b001010, "min_sw_edge2");
        cycle2(1'b0, 1'b0, 6'b000110, "min_sw_edge3");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
